// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline: merges load-use, branch flush and
// data-memory handshake into PC, IF/ID and ID/EX controls, with saturating perf counters.
module pipeline_stall_controller #(
    parameter int CNT_WIDTH = 32,
    parameter int MAX_WAIT  = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 hazard_i,
    input  logic                 branch_i,
    input  logic                 mem_req_i,
    input  logic                 mem_ack_i,
    output logic                 PCWrite_o,
    output logic                 IFID_write_o,
    output logic                 IFID_flush_o,
    output logic                 IDEX_noop_o,
    output logic                 freeze_o,
    output logic                 error_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o,
    output logic [CNT_WIDTH-1:0] flush_cnt_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_nextState;
    logic [15:0]            r_waitCnt;
    logic [16:0]            w_waitNext;
    logic                   w_memHold;
    logic                   r_error;
    logic [CNT_WIDTH-1:0]   r_stallCnt;
    logic [CNT_WIDTH-1:0]   r_flushCnt;

    // In RUN only an unacknowledged request freezes; once waiting, anything short of an ack holds.
    always_comb begin
        w_memHold = 1'b0;
        case (r_state)
            RUN:      w_memHold = mem_req_i & ~mem_ack_i;
            MEM_WAIT: w_memHold = ~mem_ack_i;
            default:  w_memHold = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (start_i) w_nextState = RUN;
            end
            RUN: begin
                if (w_memHold)     w_nextState = MEM_WAIT;
                else if (!start_i) w_nextState = IDLE;
            end
            MEM_WAIT: begin
                if (!w_memHold) w_nextState = start_i ? RUN : IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        PCWrite_o    = 1'b0;
        IFID_write_o = 1'b0;
        IFID_flush_o = 1'b0;
        IDEX_noop_o  = 1'b0;
        freeze_o     = 1'b0;
        if (r_state == RUN || r_state == MEM_WAIT) begin
            if (w_memHold) begin
                freeze_o = 1'b1;
            end else if (hazard_i) begin
                IDEX_noop_o = 1'b1;
            end else if (branch_i) begin
                PCWrite_o    = 1'b1;
                IFID_write_o = 1'b1;
                IFID_flush_o = 1'b1;
            end else begin
                PCWrite_o    = 1'b1;
                IFID_write_o = 1'b1;
            end
        end else begin
            freeze_o = 1'b1;
        end
    end

    assign w_waitNext = {1'b0, r_waitCnt} + 17'd1;

    // The wait count saturates so a never-acked access cannot wrap and hide the error.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_waitCnt <= '0;
            r_error   <= 1'b0;
        end else begin
            if (r_state == RUN && w_nextState == MEM_WAIT) begin
                r_waitCnt <= '0;
            end else if (r_state == MEM_WAIT && w_memHold) begin
                if (r_waitCnt != 16'hFFFF) r_waitCnt <= w_waitNext[15:0];
                if (w_waitNext >= 17'(MAX_WAIT)) r_error <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else if (r_state != IDLE) begin
            if ((freeze_o || IDEX_noop_o) && (r_stallCnt != '1)) r_stallCnt <= r_stallCnt + 1'b1;
            if (IFID_flush_o && (r_flushCnt != '1))              r_flushCnt <= r_flushCnt + 1'b1;
        end
    end

    assign error_o     = r_error;
    assign stall_cnt_o = r_stallCnt;
    assign flush_cnt_o = r_flushCnt;

endmodule
